// File: rtl/iob_native_sram_resp_if.sv
// iob native bus bundle between an initiator (CPU wrapper or interconnect) and an SRAM responder.
interface iob_native_sram_resp_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                  valid;
    logic [ADDR_W-1:0]     address;
    logic [DATA_W-1:0]     wdata;
    logic [DATA_W/8-1:0]   wstrb;
    logic [DATA_W-1:0]     rdata;
    logic                  ready;
    logic                  wprot_err;

    modport master (
        output valid, address, wdata, wstrb,
        input  rdata, ready, wprot_err
    );

    modport slave (
        input  valid, address, wdata, wstrb,
        output rdata, ready, wprot_err
    );
endinterface

// File: rtl/iob_native_sram_resp.sv
// iob native responder backed by an internal word-addressed SRAM with WAIT_CYCLES wait states.
// Define IOB_SRAM_WPROT_EN to discard (but still acknowledge) writes to the low WPROT_WORDS words.
//
// state  | meaning
// -------+--------------------------------------------------------------
// S_IDLE | waiting for valid; request accepted and RAM accessed here
// S_WAIT | counting down wait states, leaves when the counter hits 1
// S_RESP | one-cycle ready pulse carrying rdata (0 for writes)
module iob_native_sram_resp #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int MEM_ADDR_W  = 12,
    parameter int WAIT_CYCLES = 1,
    parameter int WPROT_WORDS = 256
) (
    input logic                   clk,
    input logic                   rst,
    iob_native_sram_resp_if.slave bus
);

    localparam int         STRB_W  = DATA_W / 8;
    localparam int         DEPTH   = 2 ** MEM_ADDR_W;
    localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t                  state_q;
    state_t                  state_d;
    logic [3:0]              cnt_q;
    logic                    write_q;
    logic                    accept;
    logic                    do_write;
    logic [MEM_ADDR_W-1:0]   idx_d;
    logic [DATA_W-1:0]       rd_q;
    logic [DATA_W-1:0]       mem [DEPTH];

    // Upper address bits are ignored, so the RAM aliases across the address space.
    assign idx_d  = bus.address[MEM_ADDR_W+1:2];
    assign accept = (state_q == S_IDLE) && bus.valid && !rst;

`ifdef IOB_SRAM_WPROT_EN
    logic prot_d;
    logic prot_q;

    assign prot_d   = (32'(idx_d) < 32'(WPROT_WORDS)) && (bus.wstrb != '0);
    assign do_write = !prot_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prot_q <= 1'b0;
        end else if (accept) begin
            prot_q <= prot_d;
        end
    end
`else
    assign do_write = 1'b1;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            write_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                cnt_q   <= WAIT_LD;
                write_q <= |bus.wstrb;
            end else if (state_q == S_WAIT) begin
                cnt_q <= cnt_q - 4'd1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (bus.valid) state_d = (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
            S_WAIT: if (cnt_q == 4'd1) state_d = S_RESP;
            S_RESP: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // RAM is read and written once, at the acceptance edge; the read word waits in rd_q.
    always_ff @(posedge clk) begin
        if (accept) begin
            rd_q <= mem[idx_d];
            if (do_write) begin
                for (int i = 0; i < STRB_W; i++) begin
                    if (bus.wstrb[i]) begin
                        mem[idx_d][8*i +: 8] <= bus.wdata[8*i +: 8];
                    end
                end
            end
        end
    end

    always_comb begin
        bus.ready     = 1'b0;
        bus.rdata     = '0;
        bus.wprot_err = 1'b0;
        if (state_q == S_RESP) begin
            bus.ready = 1'b1;
            if (!write_q) bus.rdata = rd_q;
`ifdef IOB_SRAM_WPROT_EN
            bus.wprot_err = prot_q;
`endif
        end
    end

endmodule

// File: tb/tb_iob_native_sram_resp.sv
// Self-checking bench: four responders with different wait-state counts, directed steps plus random traffic.
module tb_iob_native_sram_resp;

    localparam int NDUT = 4;
    localparam int WAITS [NDUT] = '{1, 0, 15, 4};

    logic        clk;
    logic        rst;
    logic        valid   [NDUT];
    logic [31:0] address [NDUT];
    logic [31:0] wdata   [NDUT];
    logic [3:0]  wstrb   [NDUT];
    logic [31:0] rdata   [NDUT];
    logic        ready   [NDUT];
    logic        err     [NDUT];

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] ref_mem [int];

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        iob_native_sram_resp_if #(.ADDR_W(32), .DATA_W(32)) bus ();
        assign bus.valid   = valid[g];
        assign bus.address = address[g];
        assign bus.wdata   = wdata[g];
        assign bus.wstrb   = wstrb[g];
        assign rdata[g]    = bus.rdata;
        assign ready[g]    = bus.ready;
        assign err[g]      = bus.wprot_err;

        iob_native_sram_resp #(
            .ADDR_W(32), .DATA_W(32), .MEM_ADDR_W(12),
            .WAIT_CYCLES(WAITS[g]), .WPROT_WORDS(256)
        ) dut (
            .clk (clk),
            .rst (rst),
            .bus (bus)
        );
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int key(input int k, input logic [31:0] a);
        return k * 4096 + int'(a[13:2]);
    endfunction

    function automatic bit exp_prot(input logic [31:0] a, input logic [3:0] ws);
`ifdef IOB_SRAM_WPROT_EN
        return (ws != 4'd0) && (a[13:2] < 12'd256);
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [31:0] model_read(input int k, input logic [31:0] a);
        if (ref_mem.exists(key(k, a))) return ref_mem[key(k, a)];
        return 32'hxxxx_xxxx;
    endfunction

    task automatic model_write(input int k, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws);
        logic [31:0] m;
        if (ws == 4'd0 || exp_prot(a, ws)) return;
        m = model_read(k, a);
        for (int i = 0; i < 4; i++) if (ws[i]) m[8*i +: 8] = wd[8*i +: 8];
        ref_mem[key(k, a)] = m;
    endtask

    // Starts in an IDLE cycle; ends #1 after the edge closing the ready cycle (DUT back in IDLE).
    task automatic txn(input int k, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws,
                       input bit chk_rd, input bit hold, output logic [31:0] got);
        logic [31:0] exp_rd;
        bit          exp_err;
        int          lat;
        lat     = WAITS[k];
        exp_err = exp_prot(a, ws);
        exp_rd  = (ws != 4'd0) ? 32'd0 : model_read(k, a);
        got     = '0;
        valid[k] = 1'b1; address[k] = a; wdata[k] = wd; wstrb[k] = ws;
        @(posedge clk);
        model_write(k, a, wd, ws);
        #1;
        address[k] = $urandom; wdata[k] = $urandom; wstrb[k] = 4'($urandom);
        for (int j = 1; j <= lat + 1; j++) begin
            @(negedge clk);
            if (j == lat + 1) begin
                chk($sformatf("d%0d ready_pulse", k), 32'(ready[k]), 32'd1);
                if (ws != 4'd0 || chk_rd) chk($sformatf("d%0d rdata a=%h", k, a), rdata[k], exp_rd);
                chk($sformatf("d%0d wprot_err", k), 32'(err[k]), 32'(exp_err));
                got = rdata[k];
                if (!hold) valid[k] = 1'b0;
            end else begin
                chk($sformatf("d%0d ready_early j=%0d", k, j), 32'(ready[k]), 32'd0);
                chk($sformatf("d%0d rdata_wait", k), rdata[k], 32'd0);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_chk(input int n);
        for (int k = 0; k < NDUT; k++) valid[k] = 1'b0;
        repeat (n) begin
            @(negedge clk);
            for (int k = 0; k < NDUT; k++)
                chk($sformatf("d%0d idle_outputs", k), {ready[k] ? 32'd1 : 32'd0} | rdata[k] | 32'(err[k]), 32'd0);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] got, old;
        int          w;
        logic [31:0] a;
        logic [3:0]  ws;

        rst = 1'b1;
        for (int k = 0; k < NDUT; k++) begin
            valid[k] = 1'b0; address[k] = '0; wdata[k] = '0; wstrb[k] = '0;
        end

        repeat (3) begin
            @(negedge clk);
            for (int k = 0; k < NDUT; k++)
                chk($sformatf("d%0d reset_outputs", k), {ready[k] ? 32'd1 : 32'd0} | rdata[k] | 32'(err[k]), 32'd0);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        idle_chk(10);

        // Full write/read and byte strobes on the WAIT_CYCLES=1 instance.
        txn(0, 32'h0000_0400, 32'hDEAD_BEEF, 4'hF, 1'b0, 1'b0, got);
        idle_chk(1);
        txn(0, 32'h0000_0400, 32'h0, 4'h0, 1'b1, 1'b0, got);
        chk("wr_rd_deadbeef", got, 32'hDEAD_BEEF);
        txn(0, 32'h0000_0400, 32'h1122_3344, 4'h5, 1'b0, 1'b0, got);
        txn(0, 32'h0000_0400, 32'h0, 4'h0, 1'b1, 1'b0, got);
        chk("byte_strobe", got, 32'hDE22_BE44);

        // Aliasing: upper address bits above the RAM index are ignored.
        txn(0, 32'h0000_0010, 32'hCAFE_F00D, 4'hF, 1'b0, 1'b0, got);
        txn(0, 32'h0000_4010, 32'h0, 4'h0, 1'b1, 1'b0, got);
        chk("alias", got, 32'hCAFE_F00D);

        // Latency and back-to-back with valid held, WAIT_CYCLES=0 and 15.
        txn(1, 32'h0000_0020, 32'h0102_0304, 4'hF, 1'b0, 1'b1, got);
        txn(1, 32'h0000_0020, 32'h0, 4'h0, 1'b1, 1'b1, got);
        txn(1, 32'h0000_0024, 32'hA5A5_5A5A, 4'hF, 1'b0, 1'b1, got);
        txn(1, 32'h0000_0024, 32'h0, 4'h0, 1'b1, 1'b0, got);
        txn(2, 32'h0000_0030, 32'h7777_8888, 4'hF, 1'b0, 1'b1, got);
        txn(2, 32'h0000_0030, 32'h0, 4'h0, 1'b1, 1'b1, got);
        txn(2, 32'h0000_0030, 32'h0, 4'h0, 1'b1, 1'b0, got);
        chk("lat15_rd", got, 32'h7777_8888);
        idle_chk(2);

        // Reset during WAIT abandons the response; the next read completes normally.
        txn(3, 32'h0000_0500, 32'h600D_D00D, 4'hF, 1'b0, 1'b0, got);
        valid[3] = 1'b1; address[3] = 32'h0000_0500; wdata[3] = '0; wstrb[3] = 4'h0;
        @(posedge clk);
        #1 valid[3] = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("rst_mid_ready", 32'(ready[3]), 32'd0);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (6) begin
            @(negedge clk);
            chk("post_rst_no_pulse", 32'(ready[3]), 32'd0);
        end
        @(posedge clk);
        #1;
        txn(3, 32'h0000_0500, 32'h0, 4'h0, 1'b1, 1'b0, got);
        chk("after_rst_rd", got, 32'h600D_D00D);

        // Low-word write protection.
`ifdef IOB_SRAM_WPROT_EN
        txn(0, 32'h0000_0008, 32'h0, 4'h0, 1'b0, 1'b0, old);
        txn(0, 32'h0000_0008, 32'h1234_5678, 4'hF, 1'b0, 1'b0, got);
        txn(0, 32'h0000_0008, 32'h0, 4'h0, 1'b0, 1'b0, got);
        chk("wprot_unchanged", got, old);
`else
        txn(0, 32'h0000_0008, 32'h1234_5678, 4'hF, 1'b0, 1'b0, got);
        txn(0, 32'h0000_0008, 32'h0, 4'h0, 1'b1, 1'b0, got);
        chk("noprot_stored", got, 32'h1234_5678);
`endif
        txn(0, 32'h0000_0400, 32'h8765_4321, 4'hF, 1'b0, 1'b0, got);
        txn(0, 32'h0000_0400, 32'h0, 4'h0, 1'b1, 1'b0, got);
        chk("word256_stored", got, 32'h8765_4321);

        // Random traffic against the reference memory on every instance.
        for (int k = 0; k < NDUT; k++) begin
            for (int i = 0; i < 8; i++)
                txn(k, 32'((300 + i) << 2), $urandom, 4'hF, 1'b0, 1'b0, got);
            for (int r = 0; r < 20; r++) begin
                w  = 300 + $urandom_range(0, 7);
                a  = ($urandom & 32'hFFFF_C000) | 32'(w << 2) | 32'($urandom_range(0, 3));
                ws = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'h0;
                txn(k, a, $urandom, ws, 1'b1, 1'($urandom_range(0, 1)), got);
            end
            idle_chk(1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
